// File: rtl/int_gen_pkg.sv
// Shared constants, FSM state type and byte-lane merge helper for the
// programmable interrupt generator.
package int_gen_pkg;

    localparam logic [1:0] REG_ACK    = 2'd0;
    localparam logic [1:0] REG_CTRL   = 2'd1;
    localparam logic [1:0] REG_PERIOD = 2'd2;
    localparam logic [1:0] REG_COUNT  = 2'd3;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_MODE = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_COUNT = 2'd2,
        ST_FIRE  = 2'd3
    } state_t;

    // Replace each byte of old_word whose enable bit is set with the new byte.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  byteen);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (byteen[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                merged[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/int_generator.sv
// Memory-mapped interrupt source: counts down a programmable period, raises
// interrupt and holds it until the CPU writes the ACK register.
module int_generator
    import int_gen_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m_int_addr,
    input  logic [3:0]  m_int_byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        interrupt
);

    state_t      state_r;
    state_t      state_nxt_s;
    logic [1:0]  ctrl_r;
    logic [31:0] period_r;
    logic [31:0] count_r;
    logic [31:0] count_nxt_s;
    logic        en_clr_s;

    logic [29:0] word_off_s;
    logic        in_window_s;
    logic [1:0]  reg_sel_s;
    logic        wr_s;
    logic        ack_wr_s;
    logic        ctrl_wr_s;
    logic        period_wr_s;
    logic [31:0] eff_period_s;
    logic        unused_addr_s;

    // Subtracting the base makes the window test work for any word-aligned base.
    assign word_off_s    = m_int_addr[31:2] - BASE_ADDR[31:2];
    assign in_window_s   = (word_off_s < 30'd4);
    assign reg_sel_s     = word_off_s[1:0];
    assign wr_s          = (m_int_byteen != 4'b0000) && in_window_s;
    assign ack_wr_s      = wr_s && (reg_sel_s == REG_ACK);
    assign ctrl_wr_s     = wr_s && (reg_sel_s == REG_CTRL);
    assign period_wr_s   = wr_s && (reg_sel_s == REG_PERIOD);
    assign eff_period_s  = (period_r == 32'd0) ? 32'd1 : period_r;
    assign unused_addr_s = ^m_int_addr[1:0];

    assign interrupt = (state_r == ST_FIRE);

    // Next-state, counter update and one-shot EN clear.
    always_comb begin
        state_nxt_s = state_r;
        count_nxt_s = count_r;
        en_clr_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (ctrl_r[CTRL_EN]) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                count_nxt_s = eff_period_s;
                state_nxt_s = ST_COUNT;
            end
            ST_COUNT: begin
                if (!ctrl_r[CTRL_EN]) begin
                    state_nxt_s = ST_IDLE;
                end else if (count_r <= 32'd1) begin
                    state_nxt_s = ST_FIRE;
                end else begin
                    count_nxt_s = count_r - 32'd1;
                end
            end
            ST_FIRE: begin
                if (ack_wr_s) begin
                    if (ctrl_r[CTRL_MODE] && ctrl_r[CTRL_EN]) begin
                        state_nxt_s = ST_LOAD;
                    end else begin
                        state_nxt_s = ST_IDLE;
                        en_clr_s    = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_FIRE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state and down-counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            count_r <= 32'd0;
        end else begin
            state_r <= state_nxt_s;
            count_r <= count_nxt_s;
        end
    end

    // CTRL register; bus writes and the one-shot clear never share a cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_r <= 2'b00;
        end else if (ctrl_wr_s && m_int_byteen[0]) begin
            ctrl_r <= wdata[1:0];
        end else if (en_clr_s) begin
            ctrl_r[CTRL_EN] <= 1'b0;
        end else begin
            ctrl_r <= ctrl_r;
        end
    end

    // PERIOD register with byte-lane merge; only sampled by LOAD.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            period_r <= 32'd0;
        end else if (period_wr_s) begin
            period_r <= byte_merge(period_r, wdata, m_int_byteen);
        end else begin
            period_r <= period_r;
        end
    end

    // Combinational diagnostic read port.
    always_comb begin
        rdata = 32'd0;
        if (in_window_s) begin
            case (reg_sel_s)
                REG_ACK:    rdata = 32'd0;
                REG_CTRL:   rdata = {30'd0, ctrl_r};
                REG_PERIOD: rdata = period_r;
                REG_COUNT:  rdata = count_r;
                default:    rdata = 32'd0;
            endcase
        end else begin
            rdata = 32'd0;
        end
    end

endmodule

// File: tb/tb_int_generator.sv
// Directed scoreboard bench for int_generator: expected values are queued as
// stimulus is applied and popped when the DUT response is sampled.
module tb_int_generator;

    localparam logic [31:0] BASE   = 32'h0000_7F20;
    localparam logic [31:0] O_ACK  = 32'h0;
    localparam logic [31:0] O_CTRL = 32'h4;
    localparam logic [31:0] O_PER  = 32'h8;
    localparam logic [31:0] O_CNT  = 32'hC;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] m_int_addr = 32'd0;
    logic [3:0]  m_int_byteen = 4'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        interrupt;

    int          n_vec = 0;
    int          n_miss = 0;
    logic [31:0] exp_q[$];

    int_generator #(.BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .m_int_addr(m_int_addr),
        .m_int_byteen(m_int_byteen), .wdata(wdata),
        .rdata(rdata), .interrupt(interrupt)
    );

    always #5 clk = ~clk;

    task automatic push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] ex;
        if (exp_q.size() == 0) begin
            ex = 32'hDEAD_BEEF;
        end else begin
            ex = exp_q.pop_front();
        end
        n_vec++;
        assert (obs === ex) else begin
            n_miss++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, ex);
        end
    endtask

    // Write lands on the next rising edge; returns at that edge + 1.
    task automatic wr(input logic [31:0] off, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        m_int_addr   = BASE + off;
        wdata        = d;
        m_int_byteen = be;
        @(posedge clk);
        #1;
        m_int_byteen = 4'd0;
        m_int_addr   = 32'd0;
    endtask

    task automatic rd(input logic [31:0] off, output logic [31:0] d);
        @(negedge clk);
        m_int_addr = BASE + off;
        #1;
        d = rdata;
        m_int_addr = 32'd0;
    endtask

    // Edges until interrupt is seen high, bounded by limit.
    task automatic wait_irq(input int limit, output int edges);
        edges = 0;
        while (!interrupt && edges < limit) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    initial begin
        logic [31:0] d;
        int          e;

        // Reset state
        #12;
        push(32'd0); check("rst_irq", {31'd0, interrupt});
        push(32'd0); rd(O_CTRL, d); check("rst_ctrl", d);
        push(32'd0); rd(O_PER, d);  check("rst_period", d);
        push(32'd0); rd(O_CNT, d);  check("rst_count", d);
        @(negedge clk); reset = 1'b1;

        // One-shot, PERIOD=5
        wr(O_PER, 32'd5, 4'hF);
        push(32'd7); wr(O_CTRL, 32'h1, 4'hF); wait_irq(50, e); check("oneshot_lat", e);
        push(32'd0); wr(O_ACK, 32'h0, 4'hF); check("oneshot_ack", {31'd0, interrupt});
        push(32'd0); rd(O_CTRL, d); check("oneshot_ctrl", d);
        push(32'd20); wait_irq(20, e); check("oneshot_norefire", e);

        // Periodic, PERIOD=3
        wr(O_PER, 32'd3, 4'hF);
        push(32'd5); wr(O_CTRL, 32'h3, 4'hF); wait_irq(50, e); check("per_first", e);
        for (int k = 0; k < 3; k++) begin
            push(32'd0); wr(O_ACK, 32'h0, 4'hF); check("per_ack", {31'd0, interrupt});
            push(32'd4); wait_irq(50, e); check("per_refire", e);
        end
        wr(O_CTRL, 32'h0, 4'hF);
        push(32'd1); check("per_en_clr_hold", {31'd0, interrupt});
        push(32'd0); wr(O_ACK, 32'h0, 4'hF); check("per_stop", {31'd0, interrupt});
        push(32'd15); wait_irq(15, e); check("per_norefire", e);

        // PERIOD=0 behaves as 1
        wr(O_PER, 32'd0, 4'hF);
        push(32'd3); wr(O_CTRL, 32'h1, 4'hF); wait_irq(50, e); check("p0_lat", e);
        push(32'd0); wr(O_ACK, 32'h0, 4'hF); check("p0_ack", {31'd0, interrupt});

        // Byte-lane merge and window decode
        wr(O_PER, 32'hAABB_CCDD, 4'hF);
        wr(O_PER, 32'h1122_3344, 4'b0101);
        push(32'hAA22_CC44); rd(O_PER, d); check("byte_merge", d);
        wr(32'h10, 32'hFFFF_FFFF, 4'hF);
        push(32'd0); rd(32'h10, d); check("out_of_window_rd", d);
        push(32'hAA22_CC44); rd(O_PER, d); check("out_of_window_wr", d);
        push(32'h0); rd(O_CTRL | 32'h3, d); check("addr_lsb_ignored", d);

        // Spurious ACK during COUNT, then EN cleared in FIRE
        wr(O_PER, 32'd5, 4'hF);
        wr(O_CTRL, 32'h1, 4'hF);
        push(32'd6); wr(O_ACK, 32'h0, 4'hF); wait_irq(50, e); check("spurious_ack", e);
        wr(O_CTRL, 32'h0, 4'hF);
        repeat (3) @(posedge clk);
        #1;
        push(32'd1); check("en_clr_in_fire", {31'd0, interrupt});
        push(32'd0); wr(O_ACK, 32'h0, 4'hF); check("late_ack", {31'd0, interrupt});
        push(32'd10); wait_irq(10, e); check("late_norefire", e);

        // Asynchronous reset at COUNT=2
        wr(O_PER, 32'd5, 4'hF);
        wr(O_CTRL, 32'h1, 4'hF);
        repeat (5) @(posedge clk);
        #2;
        m_int_addr = BASE + O_CNT;
        #1;
        push(32'd2); check("count_at_2", rdata);
        reset = 1'b0;
        #1;
        push(32'd0); check("rst_mid_count_irq", {31'd0, interrupt});
        push(32'd0); check("rst_mid_count_cnt", rdata);
        m_int_addr = BASE + O_PER;
        #1;
        push(32'd0); check("rst_mid_count_per", rdata);
        @(negedge clk); reset = 1'b1; m_int_addr = 32'd0;
        push(32'd20); wait_irq(20, e); check("rst_count_nofire", e);

        // Asynchronous reset during FIRE
        wr(O_PER, 32'd2, 4'hF);
        push(32'd4); wr(O_CTRL, 32'h1, 4'hF); wait_irq(50, e); check("fire_lat", e);
        #2;
        reset = 1'b0;
        #1;
        push(32'd0); check("rst_fire_irq", {31'd0, interrupt});
        m_int_addr = BASE + O_CTRL;
        #1;
        push(32'd0); check("rst_fire_ctrl", rdata);
        @(negedge clk); reset = 1'b1; m_int_addr = 32'd0;
        push(32'd20); wait_irq(20, e); check("rst_fire_nofire", e);

        if (exp_q.size() != 0) begin
            n_miss++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
